dig_bcd_conv: RTL and testbench

Bus-side front end for the 8-digit seven-segment display. Captures a 32-bit unsigned binary value written by the CPU over the bridge, converts it to eight packed BCD digits with a sequential shift-add-3 (double-dabble) engine, and holds the result on a 32-bit output. The output feeds the display scanner's data input, one nibble per digit, with digit 0 in bits [3:0]. Values above 99,999,999 are flagged as overflow and drive a fixed blanking code.

---
 rtl/dig_bcd_conv_if.sv | 13 +
 rtl/dig_bcd_conv.sv | 125 ++++++++++++
 tb/tb_dig_bcd_conv.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dig_bcd_conv_if.sv
// dig_bcd_conv_if: CPU bridge write bus into the display BCD front end.
//   addr_from_bg  - 32-bit bus address
//   we_from_bg    - single-cycle write strobe
//   wdata_from_bg - 32-bit write data
// master drives the bus (bridge / testbench), slave receives it (dig_bcd_conv).
interface dig_bcd_conv_if;
  logic [31:0] addr_from_bg;
  logic        we_from_bg;
  logic [31:0] wdata_from_bg;

  modport master (output addr_from_bg, output we_from_bg, output wdata_from_bg);
  modport slave  (input  addr_from_bg, input  we_from_bg, input  wdata_from_bg);
endinterface

// File: rtl/dig_bcd_conv.sv
// dig_bcd_conv: captures a 32-bit binary value written over the bridge and
// converts it to eight packed BCD digits (digit 0 in [3:0]) using a
// sequential shift-add-3 engine (32 iterations, one per cycle), then commits
// the result. Values above 99,999,999 drive OVF_CODE and raise conv_ovf.
// Optional feature macro: DIG_HEX_BYPASS_EN (raw hex write to BYPASS_ADDR).
// Ports:
//   clk_from_bg     - system clock, rising edge
//   rst_n_from_bg   - asynchronous active-low reset
//   bus             - bridge write bus (dig_bcd_conv_if.slave)
//   disp_data_2_dig - registered packed BCD / raw hex to the display scanner
//   conv_busy       - registered, high while converting or committing
//   conv_ovf        - registered, last committed conversion overflowed
module dig_bcd_conv #(
  parameter logic [31:0] DIG_ADDR    = 32'hFFFF_F000,
  parameter logic [31:0] BYPASS_ADDR = 32'hFFFF_F004,
  parameter logic [31:0] OVF_CODE    = 32'hFFFF_FFFF
) (
  input  logic               clk_from_bg,
  input  logic               rst_n_from_bg,
  dig_bcd_conv_if.slave      bus,
  output logic [31:0]        disp_data_2_dig,
  output logic               conv_busy,
  output logic               conv_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] bin, bin_n;
  logic [39:0] bcd, bcd_n;
  logic [5:0]  cnt, cnt_n;
  logic [31:0] disp_n;
  logic        ovf_n;
  logic        dig_hit;

  // The two register addresses must be distinct for the decode to make sense.
  if (BYPASS_ADDR == DIG_ADDR) begin : g_addr_clash
    $error("dig_bcd_conv: BYPASS_ADDR must differ from DIG_ADDR");
  end

  assign dig_hit = bus.we_from_bg && (bus.addr_from_bg == DIG_ADDR);

  function automatic logic [39:0] add3(input logic [39:0] v);
    logic [39:0] r;
    r = v;
    for (int unsigned i = 0; i < 10; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    logic [39:0] adj;
    state_n = state;
    bin_n   = bin;
    bcd_n   = bcd;
    cnt_n   = cnt;
    disp_n  = disp_data_2_dig;
    ovf_n   = conv_ovf;
    adj     = add3(bcd);

    case (state)
      CONV: begin
        bcd_n = {adj[38:0], bin[31]};
        bin_n = {bin[30:0], 1'b0};
        cnt_n = cnt + 6'd1;
        if (cnt == 6'd31) state_n = DONE;
      end
      DONE: begin
        if (bcd[39:32] == 8'd0) begin
          disp_n = bcd[31:0];
          ovf_n  = 1'b0;
        end else begin
          disp_n = OVF_CODE;
          ovf_n  = 1'b1;
        end
        state_n = IDLE;
      end
      default: ;
    endcase

`ifdef DIG_HEX_BYPASS_EN
    if (!dig_hit && bus.we_from_bg && (bus.addr_from_bg == BYPASS_ADDR)) begin
      disp_n  = bus.wdata_from_bg;
      ovf_n   = 1'b0;
      state_n = IDLE;
    end
`else
`endif

    // A load only overrides the engine registers; a commit already decided in
    // DONE still reaches the outputs, so back-to-back conversions lose nothing.
    if (dig_hit) begin
      bin_n   = bus.wdata_from_bg;
      bcd_n   = '0;
      cnt_n   = '0;
      state_n = CONV;
    end
  end

  always_ff @(posedge clk_from_bg or negedge rst_n_from_bg) begin
    if (!rst_n_from_bg) begin
      state           <= IDLE;
      bin             <= '0;
      bcd             <= '0;
      cnt             <= '0;
      disp_data_2_dig <= '0;
      conv_busy       <= 1'b0;
      conv_ovf        <= 1'b0;
    end else begin
      state           <= state_n;
      bin             <= bin_n;
      bcd             <= bcd_n;
      cnt             <= cnt_n;
      disp_data_2_dig <= disp_n;
      conv_busy       <= (state_n != IDLE);
      conv_ovf        <= ovf_n;
    end
  end

endmodule

// File: tb/tb_dig_bcd_conv.sv
module tb_dig_bcd_conv;
  localparam logic [31:0] DIG_A = 32'hFFFF_F000;
  localparam logic [31:0] BYP_A = 32'hFFFF_F004;

  logic        clk;
  logic        rst_n;
  logic [31:0] disp;
  logic        busy;
  logic        ovf;
  int          n_checks;
  int          n_pass;

  dig_bcd_conv_if bus_if ();

  dig_bcd_conv #(
    .DIG_ADDR   (DIG_A),
    .BYPASS_ADDR(BYP_A),
    .OVF_CODE   (32'hFFFF_FFFF)
  ) dut (
    .clk_from_bg    (clk),
    .rst_n_from_bg  (rst_n),
    .bus            (bus_if.slave),
    .disp_data_2_dig(disp),
    .conv_busy      (busy),
    .conv_ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drives one write; returns 1 ns after the sampling edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.addr_from_bg  = addr;
    bus_if.wdata_from_bg = data;
    bus_if.we_from_bg    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.we_from_bg    = 1'b0;
  endtask

  task automatic run_conv(input string tag, input logic [31:0] data,
                          input logic [31:0] exp, input logic exp_ovf,
                          input logic [31:0] prev);
    bus_write(DIG_A, data);
    check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    repeat (32) @(posedge clk);
    #1;
    check({tag, "_busy_e32"}, {31'd0, busy}, 32'd1);
    check({tag, "_hold_e32"}, disp, prev);
    @(posedge clk);
    #1;
    check({tag, "_data"}, disp, exp);
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic bad;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus_if.addr_from_bg  = '0;
    bus_if.wdata_from_bg = '0;
    bus_if.we_from_bg    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_disp", disp, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_conv("c12345678", 32'h00BC_614E, 32'h1234_5678, 1'b0, 32'h0000_0000);
    run_conv("czero",     32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1234_5678);
    run_conv("cmax",      32'h05F5_E0FF, 32'h9999_9999, 1'b0, 32'h0000_0000);
    run_conv("c1e8",      32'h05F5_E100, 32'hFFFF_FFFF, 1'b1, 32'h9999_9999);
    run_conv("cffff",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
    run_conv("c42",       32'd42,        32'h0000_0042, 1'b0, 32'hFFFF_FFFF);

    // Rewrite 10 cycles in: 1234 must never reach the output.
    bus_write(DIG_A, 32'd1234);
    bad = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
      if (disp !== 32'h0000_0042) bad = 1'b1;
    end
    bus_write(DIG_A, 32'd5678);
    repeat (32) begin
      @(posedge clk);
      #1;
      if (disp !== 32'h0000_0042 || busy !== 1'b1) bad = 1'b1;
    end
    check("rewrite_no_old_commit", {31'd0, bad}, 32'd0);
    @(posedge clk);
    #1;
    check("rewrite_data", disp, 32'h0000_5678);
    check("rewrite_idle", {31'd0, busy}, 32'd0);

    // Unmapped address is ignored.
    bus_write(32'hFFFF_F008, 32'h0000_0007);
    check("other_addr_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("other_addr_data", disp, 32'h0000_5678);

    // Reset mid-conversion.
    bus_write(DIG_A, 32'd999);
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_disp", disp, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("postrst_disp", disp, 32'd0);
    check("postrst_busy", {31'd0, busy}, 32'd0);

`ifdef DIG_HEX_BYPASS_EN
    bus_write(DIG_A, 32'd4321);
    repeat (4) @(posedge clk);
    bus_write(BYP_A, 32'hDEAD_BEEF);
    check("byp_data", disp, 32'hDEAD_BEEF);
    check("byp_busy", {31'd0, busy}, 32'd0);
    check("byp_ovf", {31'd0, ovf}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("byp_no_commit", disp, 32'hDEAD_BEEF);
`else
    bus_write(BYP_A, 32'hDEAD_BEEF);
    check("byp_ignored_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("byp_ignored_data", disp, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
